// File: rtl/shot_pkg.sv
// Shared types and frame packing for the shot command initiator.
package shot_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_DONE, HOLD, RELEASE} statetype;

  localparam int FRAME_BITS = 24;

  // force is a reserved word, hence frc for the compressor code
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [7:0] azi,
                                                       input logic [7:0] pol,
                                                       input logic [7:0] frc);
    return {azi, pol, frc};
  endfunction

endpackage

// File: rtl/spi_shift_out.sv
// MSB-first serialiser: sdi changes as sck falls, receiver samples on sck rise.
// done pulses in the first idle-low cycle after the final falling edge.
module spi_shift_out
  import shot_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  clr,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sck,
  output logic                  sdi,
  output logic                  done
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] sr;
  logic [DIV_W-1:0]      div_cnt;
  logic [4:0]            bit_cnt;
  logic                  active;

  // zero-filled shifting leaves sdi low once the last bit has gone out
  assign sdi = sr[FRAME_BITS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        sr      <= '0;
        sck     <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
        active  <= 1'b0;
      end else if (go) begin
        sr      <= frame;
        sck     <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
        active  <= 1'b1;
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          sck     <= ~sck;
          if (sck) begin
            sr <= {sr[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              active  <= 1'b0;
              done    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shot_cmd_tx.sv
// Shot command initiator: serialises {azi,pol,force}, arms load until both motors
// report done, holds the fire window, then pulses fired. CMD_TIMEOUT_EN adds a WAIT_DONE watchdog.
module shot_cmd_tx
  import shot_pkg::*;
#(
  parameter int SCK_DIV        = 4,
  parameter int HOLD_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] aziTarget,
  input  logic [7:0] polTarget,
  input  logic [7:0] forceCount,
  input  logic       aziDone,
  input  logic       polDone,
  output logic       sck,
  output logic       sdi,
  output logic       load,
  output logic       busy,
  output logic       fired,
  output logic       timeout
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  statetype              state;
  logic [HW-1:0]         hold_cnt;
  logic [FRAME_BITS-1:0] frame;
  logic                  go;
  logic                  shift_done;

  assign frame = pack_frame(aziTarget, polTarget, forceCount);
  assign go    = (state == IDLE) && start && !abort;

  spi_shift_out #(.SCK_DIV(SCK_DIV)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .clr   (abort),
    .frame (frame),
    .sck   (sck),
    .sdi   (sdi),
    .done  (shift_done)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
`else
  // the watchdog bound is meaningless without the watchdog
  logic [31:0] to_unused;
  assign to_unused = 32'(TIMEOUT_CYCLES);
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      load     <= 1'b0;
      busy     <= 1'b0;
      fired    <= 1'b0;
      hold_cnt <= '0;
`ifdef CMD_TIMEOUT_EN
      timeout  <= 1'b0;
      to_cnt   <= '0;
`endif
    end else begin
      fired <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      // abort outranks every transition; in IDLE these values are already in place
      if (abort) begin
        state <= IDLE;
        load  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
          SHIFT: begin
            if (shift_done) begin
              state <= WAIT_DONE;
              load  <= 1'b1;
`ifdef CMD_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
          WAIT_DONE: begin
            if (aziDone && polDone) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
`ifdef CMD_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
              state   <= IDLE;
              load    <= 1'b0;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
`endif
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state <= RELEASE;
              load  <= 1'b0;
              fired <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          RELEASE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shot_cmd_tx.sv
// Randomised bench for shot_cmd_tx: a negedge monitor summarises each shot and the
// expectations come from the frame timing rules (48*SCK_DIV clks, hold window, pulses).
module tb_shot_cmd_tx;

  localparam int D = 2;
  localparam int H = 16;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] aziTarget = 8'h00;
  logic [7:0] polTarget = 8'h00;
  logic [7:0] forceCount = 8'h00;
  logic       aziDone = 1'b0;
  logic       polDone = 1'b0;
  logic       sck, sdi, load, busy, fired, timeout;

  shot_cmd_tx #(.SCK_DIV(D), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .aziTarget(aziTarget), .polTarget(polTarget), .forceCount(forceCount),
    .aziDone(aziDone), .polDone(polDone),
    .sck(sck), .sdi(sdi), .load(load), .busy(busy), .fired(fired), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // per-shot observations, cleared by clr_mon
  int          rises, falls, last_fall_cyc, load_rise_cyc, load_hi, sck_in_load;
  int          fired_n, fired_cyc, to_n, to_cyc, busy_rise_cyc, busy_fall_cyc;
  int          min_age, age = 0;
  bit          load_seen;
  logic [23:0] cap;
  logic        p_sck = 1'b0, p_sdi = 1'b0, p_load = 1'b0, p_busy = 1'b0;

  task automatic clr_mon();
    rises = 0; falls = 0; last_fall_cyc = -1; load_rise_cyc = -1; load_hi = 0;
    sck_in_load = 0; fired_n = 0; fired_cyc = -1; to_n = 0; to_cyc = -1;
    busy_rise_cyc = -1; busy_fall_cyc = -1; min_age = 1000; load_seen = 0; cap = '0;
  endtask

  always @(negedge clk) begin
    if (sdi === p_sdi) age++; else age = 0;
    if (sck && !p_sck) begin
      rises++;
      cap = {cap[22:0], sdi};
      if (age < min_age) min_age = age;
    end
    if (!sck && p_sck) begin falls++; last_fall_cyc = cyc; end
    if (load && !p_load) begin load_seen = 1; load_rise_cyc = cyc; end
    if (load) begin load_hi++; if (sck) sck_in_load++; end
    if (fired) begin fired_n++; fired_cyc = cyc; end
    if (timeout) begin to_n++; to_cyc = cyc; end
    if (busy && !p_busy) busy_rise_cyc = cyc;
    if (!busy && p_busy) busy_fall_cyc = cyc;
    p_sck = sck; p_sdi = sdi; p_load = load; p_busy = busy;
  end

  task automatic kick(input logic [7:0] a, input logic [7:0] p, input logic [7:0] f, output int s);
    @(posedge clk); #1;
    aziTarget = a; polTarget = p; forceCount = f; start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    aziTarget = 8'($urandom); polTarget = 8'($urandom); forceCount = 8'($urandom);
  endtask

  task automatic wait_load();
    int k = 0;
    while (!load_seen && k < 400) begin @(posedge clk); #1; k++; end
    chk("load_rise_seen", 32'(load_seen), 32'd1);
  endtask

  task automatic do_shot(input logic [7:0] a, input logic [7:0] p, input logic [7:0] f,
                         input int ga, input int gp, input bit restart, input bit drop);
    int s, L, d, k;
    clr_mon();
    kick(a, p, f, s);
    if (restart) begin
      repeat (3 * D) @(posedge clk); #1;
      aziTarget = ~a; polTarget = ~p; forceCount = ~f; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_load();
    L = load_rise_cyc;
    repeat (ga) @(posedge clk); #1;
    aziDone = 1'b1;
    repeat (gp) @(posedge clk); #1;
    polDone = 1'b1;
    d = cyc;
    if (drop) begin
      repeat (2) @(posedge clk); #1;
      aziDone = 1'b0; polDone = 1'b0;
    end
    k = 0;
    while (fired_n == 0 && k < H + 200) begin @(posedge clk); #1; k++; end
    repeat (2) @(posedge clk); #1;
    aziDone = 1'b0; polDone = 1'b0;
    chk("sck_rises", 32'(rises), 32'd24);
    chk("sck_falls", 32'(falls), 32'd24);
    chk("frame", {8'h00, cap}, {8'h00, a, p, f});
    chk("sdi_setup", 32'(min_age >= D), 32'd1);
    chk("busy_rise", 32'(busy_rise_cyc), 32'(s + 1));
    chk("last_fall", 32'(last_fall_cyc), 32'(s + 1 + 48 * D));
    chk("load_rise", 32'(L), 32'(s + 2 + 48 * D));
    chk("sck_during_load", 32'(sck_in_load), 32'd0);
    chk("load_len", 32'(load_hi), 32'(d - L + 1 + H));
    chk("fired_count", 32'(fired_n), 32'd1);
    chk("fired_cyc", 32'(fired_cyc), 32'(d + H + 1));
    chk("busy_fall", 32'(busy_fall_cyc), 32'(d + H + 2));
    chk("no_timeout", 32'(to_n), 32'd0);
  endtask

  initial begin
    int s, k;
    clr_mon();
    repeat (3) @(posedge clk); #1;
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_sdi", 32'(sdi), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fired", 32'(fired), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b1;

    do_shot(8'h0A, 8'h1A, 8'h0A, 0, 50, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++)
      do_shot(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 20),
              $urandom_range(0, 60), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // abort partway through the frame
    clr_mon();
    kick(8'hC3, 8'h5A, 8'h96, s);
    k = 0;
    while (rises < 10 && k < 500) begin @(posedge clk); #1; k++; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_shift_sck", 32'(sck), 32'd0);
    chk("abort_shift_sdi", 32'(sdi), 32'd0);
    chk("abort_shift_busy", 32'(busy), 32'd0);
    repeat (150) @(posedge clk); #1;
    chk("abort_shift_rises", 32'(rises), 32'd10);
    chk("abort_shift_noload", 32'(load_seen), 32'd0);
    chk("abort_shift_nofire", 32'(fired_n), 32'd0);

    // abort together with start in IDLE
    clr_mon();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("abort_idle_busy", 32'(busy_rise_cyc), 32'hFFFF_FFFF);
    chk("abort_idle_rises", 32'(rises), 32'd0);

    // abort while waiting for the motors
    clr_mon();
    kick(8'h11, 8'h22, 8'h33, s);
    wait_load();
    repeat (5) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_wait_load", 32'(load), 32'd0);
    chk("abort_wait_busy", 32'(busy), 32'd0);
    aziDone = 1'b1; polDone = 1'b1;
    repeat (H + 10) @(posedge clk); #1;
    aziDone = 1'b0; polDone = 1'b0;
    chk("abort_wait_nofire", 32'(fired_n), 32'd0);

    // asynchronous reset in the middle of HOLD
    clr_mon();
    kick(8'h44, 8'h55, 8'h66, s);
    wait_load();
    aziDone = 1'b1; polDone = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_hold_load", 32'(load), 32'd0);
    chk("rst_hold_sck", 32'(sck), 32'd0);
    chk("rst_hold_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; aziDone = 1'b0; polDone = 1'b0;
    do_shot(8'($urandom), 8'($urandom), 8'($urandom), 3, 7, 1'b0, 1'b0);

`ifdef CMD_TIMEOUT_EN
    clr_mon();
    kick(8'h77, 8'h88, 8'h99, s);
    wait_load();
    k = 0;
    while (to_n == 0 && k < 3 * T) begin @(posedge clk); #1; k++; end
    chk("timeout_cyc", 32'(to_cyc), 32'(load_rise_cyc + T));
    chk("timeout_load_len", 32'(load_hi), 32'(T));
    chk("timeout_load", 32'(load), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk); #1;
    chk("timeout_count", 32'(to_n), 32'd1);
    chk("timeout_nofire", 32'(fired_n), 32'd0);
`else
    clr_mon();
    kick(8'h77, 8'h88, 8'h99, s);
    wait_load();
    repeat (3 * T) @(posedge clk); #1;
    chk("wait_forever_load", 32'(load), 32'd1);
    chk("wait_forever_busy", 32'(busy), 32'd1);
    chk("wait_forever_noto", 32'(to_n), 32'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("wait_forever_abort", 32'(load), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
